stream_conv3x3: RTL and testbench

- Parametrised successor to the fixed 3x3 filter path: line buffers, 3x3 window, runtime-programmable signed kernel, pipelined MAC, normalise/saturate and output stage in one block.
- Supports generic pixel width and frame size.
- Implements true end-to-end AXI-stream backpressure: the whole pipeline stalls on m_data_ready, with no FIFO prog-full approximation.
- Emits interior ("valid") convolution only, plus end-of-frame marking.

---
 rtl/stream_conv3x3_if.sv | 30 +++
 rtl/stream_conv3x3.sv | 193 +++++++++++++++++++
 tb/tb_stream_conv3x3.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_conv3x3_if.sv
// Purpose : pixel-stream bundle for stream_conv3x3: one AXI-stream-like input
//           channel, one output channel with end-of-frame marking, and a
//           frame-complete pulse.
// Signals : s_data_valid/s_data/s_data_ready  - input pixel channel
//           m_data_valid/m_data/m_data_last/m_data_ready - output pixel channel
//           frame_done - one-cycle pulse after the last output is accepted
// Modports: slave  - the filter block side
//           master - the environment side (source of pixels, sink of results)
interface stream_conv3x3_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  s_data_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_data_ready;
   logic                  m_data_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_data_last;
   logic                  m_data_ready;
   logic                  frame_done;

   modport slave (
      input  s_data_valid, s_data, m_data_ready,
      output s_data_ready, m_data_valid, m_data, m_data_last, frame_done
   );

   modport master (
      output s_data_valid, s_data, m_data_ready,
      input  s_data_ready, m_data_valid, m_data, m_data_last, frame_done
   );
endinterface

// File: rtl/stream_conv3x3.sv
// Purpose : streaming 3x3 convolution over raster-order frames. Two line
//           buffers feed a 3x3 window; a runtime-programmable signed kernel is
//           applied by a 3-stage pipeline (multiply, add tree,
//           shift/saturate). Only interior centres are emitted; the output
//           for the bottom-right interior centre carries m_data_last.
//           The whole pipeline stalls on downstream backpressure.
// Ports   : clk    - clock
//           reset  - synchronous, active-high reset
//           coeff  - 9 signed 8-bit taps, coeff[8*(3*i+j)+:8] = k[i][j]
//                    (i = row, j = col, 0 = oldest); latched at pixel (0,0)
//           bus    - stream_conv3x3_if.slave (input/output pixel channels)
// Macro   : STREAM_CONV_ABS_EN - when defined, negative filter results are
//           replaced by their magnitude before saturation instead of
//           clamping to zero.
module stream_conv3x3 #(
   parameter int DATA_WIDTH   = 8,
   parameter int IMAGE_WIDTH  = 512,
   parameter int IW_BIT_NUM   = 9,
   parameter int IMAGE_HEIGHT = 512,
   parameter int IH_BIT_NUM   = 9,
   parameter int SHIFT        = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [71:0]            coeff,
   stream_conv3x3_if.slave        bus
);
   localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int PW = DATA_WIDTH + 9;    // product: (DW+1)-bit pixel x 8-bit tap
   localparam int SW = DATA_WIDTH + 13;   // sum of 9 products, cannot overflow
   localparam logic [IW_BIT_NUM-1:0] COL_ZERO = {IW_BIT_NUM{1'b0}};
   localparam logic [IW_BIT_NUM-1:0] COL_ONE  = IW_BIT_NUM'(1);
   localparam logic [IW_BIT_NUM-1:0] COL_TWO  = IW_BIT_NUM'(2);
   localparam logic [IW_BIT_NUM-1:0] COL_LAST = IW_BIT_NUM'(IMAGE_WIDTH - 1);
   localparam logic [IH_BIT_NUM-1:0] ROW_ZERO = {IH_BIT_NUM{1'b0}};
   localparam logic [IH_BIT_NUM-1:0] ROW_ONE  = IH_BIT_NUM'(1);
   localparam logic [IH_BIT_NUM-1:0] ROW_TWO  = IH_BIT_NUM'(2);
   localparam logic [IH_BIT_NUM-1:0] ROW_LAST = IH_BIT_NUM'(IMAGE_HEIGHT - 1);
   localparam logic [DATA_WIDTH-1:0] PIX_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] PIX_ONES = {DATA_WIDTH{1'b1}};
   localparam logic signed [SW-1:0]  PIX_MAX  = $signed({{(SW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}});

   logic                     en_s, s_ready_s, accept_s;
   logic                     win_hit_s, win_end_s;
   logic [AW-1:0]            col_idx_s;
   logic [IW_BIT_NUM-1:0]    col_q, col_d;
   logic [IH_BIT_NUM-1:0]    row_q, row_d;
   logic [DATA_WIDTH-1:0]    lb_old_q [0:IMAGE_WIDTH-1];   // row r-2
   logic [DATA_WIDTH-1:0]    lb_mid_q [0:IMAGE_WIDTH-1];   // row r-1
   logic [DATA_WIDTH-1:0]    win_q [0:2][0:2];
   logic [71:0]              coeff_q;
   logic                     win_valid_q, win_last_q;
   logic signed [PW-1:0]     prod_q [0:8];
   logic                     s1_valid_q, s1_last_q;
   logic signed [SW-1:0]     sum_s, sum_q;
   logic                     s2_valid_q, s2_last_q;
   logic signed [SW-1:0]     shifted_s, mag_s;
   logic [DATA_WIDTH-1:0]    sat_s;
   logic                     m_valid_q, m_last_q, frame_done_q;
   logic [DATA_WIDTH-1:0]    m_data_q;

   // Single global enable: everything advances unless a held output is refused.
   assign en_s      = !m_valid_q | bus.m_data_ready;
   assign s_ready_s = en_s & !reset;
   assign accept_s  = bus.s_data_valid & s_ready_s;
   assign col_idx_s = col_q[AW-1:0];
   // Accepting (r,c) with r,c >= 2 completes the window centred on (r-1,c-1).
   assign win_hit_s = (col_q >= COL_TWO) && (row_q >= ROW_TWO);
   assign win_end_s = (col_q == COL_LAST) && (row_q == ROW_LAST);

   assign bus.s_data_ready = s_ready_s;
   assign bus.m_data_valid = m_valid_q;
   assign bus.m_data       = m_data_q;
   assign bus.m_data_last  = m_last_q;
   assign bus.frame_done   = frame_done_q;

   // Raster position of the next pixel to be accepted.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept_s) begin
         if (col_q == COL_LAST) begin
            col_d = COL_ZERO;
            if (row_q == ROW_LAST) begin
               row_d = ROW_ZERO;
            end else begin
               row_d = row_q + ROW_ONE;
            end
         end else begin
            col_d = col_q + COL_ONE;
            row_d = row_q;
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // Line buffers, window and multiply/add datapath (no reset needed: every
   // value is qualified by a valid bit, and rows 0-1 never produce output).
   always_ff @(posedge clk) begin
      if (accept_s) begin
         lb_old_q[col_idx_s] <= lb_mid_q[col_idx_s];
         lb_mid_q[col_idx_s] <= bus.s_data;
         for (int i = 0; i < 3; i++) begin
            win_q[i][0] <= win_q[i][1];
            win_q[i][1] <= win_q[i][2];
         end
         win_q[0][2] <= lb_old_q[col_idx_s];
         win_q[1][2] <= lb_mid_q[col_idx_s];
         win_q[2][2] <= bus.s_data;
      end
      if (en_s) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               prod_q[3*i+j] <= PW'($signed({1'b0, win_q[i][j]})) *
                                PW'($signed(coeff_q[8*(3*i+j) +: 8]));
            end
         end
         sum_q <= sum_s;
      end
   end

   // Adder tree over the nine products.
   always_comb begin
      sum_s = {SW{1'b0}};
      for (int t = 0; t < 9; t++) begin
         sum_s = sum_s + SW'(prod_q[t]);
      end
   end

   // Normalise, optionally fold negatives, then clamp into the pixel range.
   always_comb begin
      shifted_s = sum_q >>> SHIFT;
`ifdef STREAM_CONV_ABS_EN
      if (shifted_s[SW-1]) begin
         mag_s = -shifted_s;
      end else begin
         mag_s = shifted_s;
      end
`else
      mag_s = shifted_s;
`endif
      if (mag_s[SW-1]) begin
         sat_s = PIX_ZERO;
      end else if (mag_s > PIX_MAX) begin
         sat_s = PIX_ONES;
      end else begin
         sat_s = mag_s[DATA_WIDTH-1:0];
      end
   end

   // Counters, kernel latch, pipeline valid/last bits and output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q        <= COL_ZERO;
         row_q        <= ROW_ZERO;
         coeff_q      <= 72'h0;
         win_valid_q  <= 1'b0;
         win_last_q   <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_last_q    <= 1'b0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         m_data_q     <= PIX_ZERO;
         frame_done_q <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         // The new kernel takes effect from the first pixel of a frame; the
         // previous frame's last window has already left the window stage.
         if (accept_s && (col_q == COL_ZERO) && (row_q == ROW_ZERO)) begin
            coeff_q <= coeff;
         end
         frame_done_q <= m_valid_q & bus.m_data_ready & m_last_q;
         if (en_s) begin
            win_valid_q <= accept_s & win_hit_s;
            win_last_q  <= accept_s & win_end_s;
            s1_valid_q  <= win_valid_q;
            s1_last_q   <= win_last_q;
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            m_valid_q   <= s2_valid_q;
            m_last_q    <= s2_valid_q & s2_last_q;
            if (s2_valid_q) begin
               m_data_q <= sat_s;
            end
         end
      end
   end
endmodule

// File: tb/tb_stream_conv3x3.sv
// Bench for stream_conv3x3 on 4x4 frames. Two instances share all stimulus:
// dut0 with SHIFT=0 and dut3 with SHIFT=3; "sel" chooses which one the
// scoreboard watches. Expected pixels are computed by direct convolution of
// the driven image and pushed when the completing pixel is accepted.
module tb_stream_conv3x3;
   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam logic [71:0] K_ID   = 72'h000000000100000000;
   localparam logic [71:0] K_NEG  = 72'h00000000FF00000000;
   localparam logic [71:0] K_ONES = 72'h010101010101010101;

   logic          clk = 1'b0;
   logic          reset;
   logic [71:0]   coeff;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          m_ready;
   logic          sel;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int fd_cnt = 0;
   int acc22 = 0;
   logic [8:0] sbq[$];
   int outcyc[$];
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_md = 8'h00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stream_conv3x3_if #(.DATA_WIDTH(DW)) if0 ();
   stream_conv3x3_if #(.DATA_WIDTH(DW)) if1 ();

   assign if0.s_data_valid = s_valid;
   assign if0.s_data       = s_data;
   assign if0.m_data_ready = m_ready;
   assign if1.s_data_valid = s_valid;
   assign if1.s_data       = s_data;
   assign if1.m_data_ready = m_ready;

   stream_conv3x3 #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IW_BIT_NUM(3),
                    .IMAGE_HEIGHT(H), .IH_BIT_NUM(3), .SHIFT(0))
      dut0 (.clk(clk), .reset(reset), .coeff(coeff), .bus(if0));

   stream_conv3x3 #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IW_BIT_NUM(3),
                    .IMAGE_HEIGHT(H), .IH_BIT_NUM(3), .SHIFT(3))
      dut3 (.clk(clk), .reset(reset), .coeff(coeff), .bus(if1));

   logic          mv, ml, sr, fd;
   logic [DW-1:0] md;
   assign mv = sel ? if1.m_data_valid : if0.m_data_valid;
   assign ml = sel ? if1.m_data_last  : if0.m_data_last;
   assign sr = sel ? if1.s_data_ready : if0.s_data_ready;
   assign fd = sel ? if1.frame_done   : if0.frame_done;
   assign md = sel ? if1.m_data       : if0.m_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Output monitor: handshake rule, hold-while-stalled, scoreboard pop.
   always @(negedge clk) begin
      if (!reset) begin
         chk("ready_rule", 32'(sr), 32'(!mv | m_ready));
         if (prev_stall) begin
            chk("hold_valid", 32'(mv), 32'(1'b1));
            chk("hold_data", 32'(md), 32'(prev_md));
         end
         if (mv && m_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_output", 32'(sbq.size()), 32'd1);
            end else begin
               chk("data", 32'(md), 32'(sbq[0][7:0]));
               chk("last", 32'(ml), 32'(sbq[0][8]));
               void'(sbq.pop_front());
            end
            outcyc.push_back(cyc);
         end
         if (fd) fd_cnt <= fd_cnt + 1;
         prev_stall <= mv & !m_ready;
         prev_md    <= md;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   // Drive npix pixels of a frame; mode 0 = ramp 4r+c, otherwise constant val.
   task automatic send_frame(input int mode, input int val, input logic [71:0] k,
                             input int npix, input int chg_at);
      int img[0:3][0:3];
      int r, c, sum, shv;
      logic acc;
      logic [7:0] kb;
      coeff = k;
      shv = sel ? 3 : 0;
      for (int n = 0; n < npix; n++) begin
         r = n / W;
         c = n % W;
         img[r][c] = (mode == 0) ? (4 * r + c) : val;
         s_valid = 1'b1;
         s_data  = 8'(img[r][c]);
         acc = 1'b0;
         for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = sr;
            @(posedge clk);
            #1;
         end
         if (!acc) chk("accept_timeout", 32'd0, 32'd1);
         if (r == 2 && c == 2) acc22 = cyc;
         if (r >= 2 && c >= 2) begin
            sum = 0;
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  kb = k[8*(3*i+j) +: 8];
                  sum = sum + int'($signed(kb)) * img[r-2+i][c-2+j];
               end
            end
            sum = sum >>> shv;
`ifdef STREAM_CONV_ABS_EN
            if (sum < 0) sum = -sum;
`endif
            if (sum < 0) sum = 0;
            if (sum > 255) sum = 255;
            sbq.push_back({((r == H-1) && (c == W-1)) ? 1'b1 : 1'b0, 8'(sum)});
         end
         if (n == chg_at) coeff = K_ONES;
      end
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk("drain", 32'(sbq.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;
      coeff = 72'h0; sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 32'(sr), 32'd0);
      chk("rst_m_valid", 32'(mv), 32'd0);
      chk("rst_m_data", 32'(md), 32'd0);
      chk("rst_m_last", 32'(ml), 32'd0);
      chk("rst_frame_done", 32'(fd), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", 32'(sr), 32'd1);

      // Identity kernel on a ramp: 5,6,9,10, latency 3.
      send_frame(0, 0, K_ID, 16, -1);
      drain();
      chk("latency", 32'((outcyc.size() > 0 ? outcyc[0] : 0) - acc22), 32'd3);
      chk("fd_identity", 32'(fd_cnt), 32'd1);

      // Box kernel, SHIFT=3 instance: 144>>3 = 18.
      sel = 1'b1;
      send_frame(1, 16, K_ONES, 16, -1);
      drain();
      chk("fd_box", 32'(fd_cnt), 32'd2);
      sel = 1'b0;

      // Saturation high followed back-to-back by a negative-result frame.
      send_frame(1, 255, K_ONES, 16, -1);
      send_frame(1, 10, K_NEG, 16, -1);
      drain();
      chk("fd_sat_neg", 32'(fd_cnt), 32'd4);

      // Backpressure for 10 cycles, with a kernel change mid-frame.
      fork
         send_frame(0, 0, K_ID, 16, 5);
         begin
            repeat (14) @(posedge clk);
            #1;
            m_ready = 1'b0;
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 32'(mv), 32'd1);
            chk("stall_ready", 32'(sr), 32'd0);
            repeat (5) @(posedge clk);
            #1;
            m_ready = 1'b1;
         end
      join
      drain();
      chk("fd_backpressure", 32'(fd_cnt), 32'd5);

      // Reset after 7 pixels, then a clean ramp frame.
      send_frame(0, 0, K_ID, 7, -1);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_m_valid", 32'(mv), 32'd0);
      reset = 1'b0;
      send_frame(0, 0, K_ID, 16, -1);
      drain();
      chk("fd_after_reset", 32'(fd_cnt), 32'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
